// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between a byte source (core/debug unit) and the UART transmitter.
// tx_data is only meaningful while tx_valid is high; tx_done pulses once per finished frame.
interface uart_tx_serializer_if #(
   parameter int DBIT = 8
);
   logic            tx_valid;
   logic [DBIT-1:0] tx_data;
   logic            tx_ready;
   logic            tx_done;

   modport master (
      output tx_valid,
      output tx_data,
      input  tx_ready,
      input  tx_done
   );

   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_ready,
      output tx_done
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DBIT data bits LSB-first, STOP_BITS stop bits, each CLKS_PER_BIT clocks.
// One byte per valid/ready handshake; ready stays low for the whole frame and returns with tx_done.
module uart_tx_serializer #(
   parameter int DBIT         = 8,
   parameter int CLKS_PER_BIT = 5208,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_tx_serializer_if.slave  bus,
   output logic                 tx
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DBIT - 1);
   localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   idx;
   logic [DBIT-1:0] shreg;
   logic            ready_q;
   logic            done_q;
   logic            bit_end;

   assign bit_end      = (cnt == CNT_LAST);
   assign bus.tx_ready = ready_q;
   assign bus.tx_done  = done_q;

   // tx is loaded one edge ahead of each bit so the line itself is a plain flop output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               tx      <= 1'b1;
               ready_q <= 1'b1;
               if (bus.tx_valid && ready_q) begin
                  shreg   <= bus.tx_data;
                  cnt     <= '0;
                  idx     <= '0;
                  tx      <= 1'b0;
                  ready_q <= 1'b0;
                  state   <= START;
               end
            end

            START: begin
               if (bit_end) begin
                  cnt   <= '0;
                  idx   <= '0;
                  tx    <= shreg[0];
                  state <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (bit_end) begin
                  cnt   <= '0;
                  shreg <= shreg >> 1;
                  if (idx == IDX_LAST) begin
                     idx   <= '0;
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     idx <= idx + 1'b1;
                     tx  <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            STOP: begin
               // idx counts stop bits here so two-stop-bit frames reuse the same bit timer.
               if (bit_end) begin
                  cnt <= '0;
                  if (idx == STOP_LAST) begin
                     idx     <= '0;
                     done_q  <= 1'b1;
                     ready_q <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               tx      <= 1'b1;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
